dump_pulse_monitor: RTL
=======================

// Module: dump_pulse_monitor
// PURPOSE
//   Receive-side checker for the Q-dump pulse driven onto the probe switch after each transmit burst.
//   - Armed once per acquisition. Waits for the dumpon rising edge and measures the high width in clk cycles.
//   - Checks the width against a legal window, then holds off for a blanking interval.
//   - Raises rx_enable only when a legal pulse has completed. Reports errors, captured width and a done strobe.
//   - Sits between the dump pulse generator and the receiver/ADC gating logic.
// PARAMETERS
//   CNT_W     8    width of internal counter and width output; all limits below must be < 2**CNT_W
//   MIN_W     16   minimum legal pulse width, cycles (inclusive)
//   MAX_W     22   maximum legal pulse width, cycles (inclusive)
//   BLANK_CYC 8    cycles spent in BLANK after the falling edge, >=1
//   TIMEOUT   200  max cycles allowed in WAIT_RISE, and separately in HIGH, before err_timeout
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   reset        in   1      asynchronous, active-low; clears all state immediately
//   dumpon       in   1      dump pulse under test, synchronous to clk
//   arm          in   1      start one monitoring window; sampled only in IDLE
//   busy         out  1      1 in any state other than IDLE
//   done         out  1      one-cycle strobe on return to IDLE (pass or fail)
//   rx_enable    out  1      receiver gate; 1 after a clean pulse, until next accepted arm
//   width        out  CNT_W  high width of last measured pulse; held until next measurement
//   err_short    out  1      sticky: last pulse width < MIN_W
//   err_long     out  1      sticky: last pulse width > MAX_W
//   err_timeout  out  1      sticky: no rise within TIMEOUT, or dumpon high for TIMEOUT cycles
// BEHAVIOUR
//   Reset (async, reset=0)
//     - State IDLE; cnt=0; dumpon_d=1, so a pulse already high at release is never counted.
//     - All outputs 0, including width.
//   dumpon_d
//     - Registers dumpon every cycle in every state.
//     - Rise = dumpon & ~dumpon_d. Fall is detected as dumpon==0 while in HIGH.
//   IDLE
//     - arm=1 -> WAIT_RISE. Same edge: cnt=0; rx_enable, err_short, err_long, err_timeout all cleared.
//     - width is not cleared.
//   WAIT_RISE
//     - rise -> HIGH, cnt=1 (the rising sample counts as width 1).
//     - else if cnt==TIMEOUT-1 -> IDLE, err_timeout=1, done=1.
//     - else cnt++.
//     - A dumpon already high when armed is ignored until it falls and rises again.
//   HIGH
//     - dumpon=1 and cnt==TIMEOUT-1 -> IDLE, err_timeout=1, width=cnt+1, done=1.
//     - dumpon=1 otherwise -> cnt++.
//     - dumpon=0 -> BLANK, cnt=0. Same edge: width=cnt, err_short=(cnt<MIN_W), err_long=(cnt>MAX_W).
//   BLANK
//     - cnt++ each cycle.
//     - At cnt==BLANK_CYC-1 -> IDLE, done=1, rx_enable = ~(err_short|err_long).
//     - Total BLANK dwell is exactly BLANK_CYC cycles.
//     - dumpon activity during BLANK is ignored; no re-measurement.
//   Output timing
//     - done is high exactly in the first IDLE cycle after a window.
//     - busy is combinational from state (=0 in IDLE).
//     - Other outputs are registered.
//   Simultaneous / boundary cases
//     - arm while busy: ignored.
//     - arm in the same cycle done is high (IDLE): accepted, and rx_enable clears on that edge.
//     - Width MIN_W and width MAX_W are both legal.
//     - cnt never wraps: TIMEOUT bounds it below 2**CNT_W.
//     - reset low mid-window: immediate return to IDLE with all outputs 0; no done strobe.
// TESTING
//   1 Arm; rise 5 cyc later; high 19 cyc -> width=19, no errors; done + rx_enable=1 exactly 8 cyc after first low sample.
//   2 Pulses of width 15/16/22/23 -> err_short=1 / clean / clean / err_long=1; rx_enable=1 only for 16 and 22.
//   3 Arm, dumpon held 0 -> done + err_timeout=1 after 200 cyc in WAIT_RISE; rx_enable=0, width unchanged.
//   4 Arm while dumpon already high, falls, rises again for 19 cyc -> only the second pulse is measured, width=19.
//   5 Stuck high 250 cyc after rise -> err_timeout=1 and width=200 at exit; second arm while busy has no effect.
//   6 Reset low during HIGH -> all outputs 0 at once; after release, a full legal pulse passes; arm on done cycle is accepted.

Source files
------------

// File: rtl/dump_pulse_monitor_if.sv
// ---------------------------------------------------------------------------
// dump_pulse_monitor_if
//   Groups the dump-pulse monitor's stimulus and status signals.
//   master : drives dumpon/arm, observes status (pulse generator / controller side)
//   slave  : the monitor itself
//   Signals:
//     dumpon      dump pulse under test
//     arm         start one monitoring window
//     busy        monitor not in IDLE
//     done        one-cycle strobe at end of a window
//     rx_enable   receiver gate after a clean pulse
//     width       last measured high width (CNT_W bits)
//     err_short   last pulse shorter than the legal window
//     err_long    last pulse longer than the legal window
//     err_timeout no rise in time, or pulse stuck high
// ---------------------------------------------------------------------------
interface dump_pulse_monitor_if #(
  parameter int CNT_W = 8
);
  logic             dumpon;
  logic             arm;
  logic             busy;
  logic             done;
  logic             rx_enable;
  logic [CNT_W-1:0] width;
  logic             err_short;
  logic             err_long;
  logic             err_timeout;

  modport master (
    output dumpon, arm,
    input  busy, done, rx_enable, width, err_short, err_long, err_timeout
  );

  modport slave (
    input  dumpon, arm,
    output busy, done, rx_enable, width, err_short, err_long, err_timeout
  );
endinterface

// File: rtl/dump_pulse_monitor.sv
// ---------------------------------------------------------------------------
// dump_pulse_monitor
//   Receive-side checker for the Q-dump pulse. Once armed it waits for a
//   dumpon rising edge, measures the high width in clk cycles, checks it
//   against [MIN_W, MAX_W], blanks for BLANK_CYC cycles and then opens
//   rx_enable only if the pulse was legal.
//   Ports:
//     clk    system clock (rising edge)
//     reset  asynchronous, active-low
//     bus    dump_pulse_monitor_if.slave (dumpon/arm in, status out)
// ---------------------------------------------------------------------------
module dump_pulse_monitor #(
  parameter int CNT_W     = 8,
  parameter int MIN_W     = 16,
  parameter int MAX_W     = 22,
  parameter int BLANK_CYC = 8,
  parameter int TIMEOUT   = 200
) (
  input logic                clk,
  input logic                reset,
  dump_pulse_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_BLANK     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_MIN   = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] LIM_MAX   = CNT_W'(MAX_W);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [CNT_W-1:0] width_r, width_n;
  logic             dumpon_d_r;
  logic             done_r, done_n;
  logic             rx_en_r, rx_en_n;
  logic             err_short_r, err_short_n;
  logic             err_long_r, err_long_n;
  logic             err_to_r, err_to_n;
  logic             rise_s;

  assign rise_s = bus.dumpon & ~dumpon_d_r;

  // State and status registers; dumpon_d resets high so a pulse already
  // high at reset release never looks like a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      width_r     <= CNT_ZERO;
      dumpon_d_r  <= 1'b1;
      done_r      <= 1'b0;
      rx_en_r     <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      err_to_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      width_r     <= width_n;
      dumpon_d_r  <= bus.dumpon;
      done_r      <= done_n;
      rx_en_r     <= rx_en_n;
      err_short_r <= err_short_n;
      err_long_r  <= err_long_n;
      err_to_r    <= err_to_n;
    end
  end

  // Next-state and next-output logic for the measurement window.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    width_n     = width_r;
    done_n      = 1'b0;
    rx_en_n     = rx_en_r;
    err_short_n = err_short_r;
    err_long_n  = err_long_r;
    err_to_n    = err_to_r;

    case (state_r)
      ST_IDLE: begin
        // width deliberately survives a new arm; it is only replaced by a
        // fresh measurement.
        if (bus.arm) begin
          state_n     = ST_WAIT_RISE;
          cnt_n       = CNT_ZERO;
          rx_en_n     = 1'b0;
          err_short_n = 1'b0;
          err_long_n  = 1'b0;
          err_to_n    = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_WAIT_RISE: begin
        if (rise_s) begin
          // The rising sample itself is the first high cycle.
          state_n = ST_HIGH;
          cnt_n   = CNT_ONE;
        end else if (cnt_r == CNT_TO) begin
          state_n  = ST_IDLE;
          err_to_n = 1'b1;
          done_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (bus.dumpon) begin
          if (cnt_r == CNT_TO) begin
            state_n  = ST_IDLE;
            err_to_n = 1'b1;
            width_n  = cnt_r + CNT_ONE;
            done_n   = 1'b1;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          state_n     = ST_BLANK;
          cnt_n       = CNT_ZERO;
          width_n     = cnt_r;
          err_short_n = (cnt_r < LIM_MIN);
          err_long_n  = (cnt_r > LIM_MAX);
        end
      end

      ST_BLANK: begin
        // dumpon is ignored here; the window ends after a fixed dwell.
        if (cnt_r == CNT_BLANK) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          rx_en_n = ~(err_short_r | err_long_r);
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.done        = done_r;
  assign bus.rx_enable   = rx_en_r;
  assign bus.width       = width_r;
  assign bus.err_short   = err_short_r;
  assign bus.err_long    = err_long_r;
  assign bus.err_timeout = err_to_r;

endmodule
